mlp_sequencer: RTL and testbench

Control sequencer for the MLP datapath. It answers the `mlp_start` / `mlp_clear_acc` / `mlp_accumulate_mode` requests issued by the instruction execution stage and reports progress on the 4-bit `mlp_state` bus that the execution stage polls for SYNC and busy completion. Each accepted request runs one full matmul pass in order:

1. accumulator clear
2. weight load from the weight FIFO
3. weight swap
4. activation streaming from the unified buffer
5. systolic drain
6. accumulator commit
7. result writeback

---
 rtl/tpu_mlp_pkg.sv | 28 ++
 rtl/mlp_sequencer_if.sv | 44 ++++
 rtl/mlp_sequencer_phase_counter.sv | 30 +++
 rtl/mlp_sequencer.sv | 140 ++++++++++++++
 tb/tb_mlp_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_mlp_pkg.sv
// Shared MLP sequencer types: state encoding and the completion codes the
// execution stage decodes from mlp_state.
package tpu_mlp_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_CLEAR     = 4'd1,
    S_LOAD_W    = 4'd2,
    S_SWAP_W    = 4'd3,
    S_STREAM    = 4'd4,
    S_DRAIN     = 4'd5,
    S_COMMIT    = 4'd6,
    S_WRITEBACK = 4'd7,
    S_DONE      = 4'd8
  } mlp_state_t;

  // Fixed codes the execution stage polls for SYNC / busy completion
  localparam logic [STATE_W-1:0] MLP_STATE_IDLE = 4'd0;
  localparam logic [STATE_W-1:0] MLP_STATE_DONE = 4'd8;

  // A new request may only be taken while idle or in the completion cycle
  function automatic logic can_accept(input mlp_state_t s);
    return (STATE_W'(s) == MLP_STATE_IDLE) || (STATE_W'(s) == MLP_STATE_DONE);
  endfunction

endpackage

// File: rtl/mlp_sequencer_if.sv
// Request, weight-FIFO, unified-buffer, accumulator and writeback signals
// between the execution stage / datapath and the MLP sequencer.
interface mlp_sequencer_if
  import tpu_mlp_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic               mlp_start;
  logic               mlp_clear_acc;
  logic               mlp_accumulate_mode;
  logic [ADDR_W-1:0]  act_base;
  logic [ADDR_W-1:0]  out_base;
  logic               wfifo_empty;
  logic               wfifo_rd_en;
  logic               wt_load_en;
  logic               wt_swap;
  logic               ub_rd_en;
  logic [ADDR_W-1:0]  ub_rd_addr;
  logic               acc_clear;
  logic               acc_commit;
  logic               acc_add;
  logic               wb_valid;
  logic               wb_ready;
  logic [ADDR_W-1:0]  wb_addr;
  logic [STATE_W-1:0] mlp_state;
  logic               start_ignored;

  // Sequencer side
  modport master (
    input  mlp_start, mlp_clear_acc, mlp_accumulate_mode, act_base, out_base,
           wfifo_empty, wb_ready,
    output wfifo_rd_en, wt_load_en, wt_swap, ub_rd_en, ub_rd_addr, acc_clear,
           acc_commit, acc_add, wb_valid, wb_addr, mlp_state, start_ignored
  );

  // Execution stage / datapath side
  modport slave (
    output mlp_start, mlp_clear_acc, mlp_accumulate_mode, act_base, out_base,
           wfifo_empty, wb_ready,
    input  wfifo_rd_en, wt_load_en, wt_swap, ub_rd_en, ub_rd_addr, acc_clear,
           acc_commit, acc_add, wb_valid, wb_addr, mlp_state, start_ignored
  );

endinterface

// File: rtl/mlp_sequencer_phase_counter.sv
// Loadable down-counter shared by the LOAD_W, STREAM, DRAIN and WRITEBACK
// phases; zero is registered alongside the count.
module mlp_phase_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      count <= count - W'(1);
      zero  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/mlp_sequencer.sv
// MLP pass sequencer: clear, weight load, swap, activation stream, drain,
// commit and writeback, reporting progress on mlp_state.
module mlp_sequencer
  import tpu_mlp_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned ADDR_W  = 8
) (
  input logic            clk,
  input logic            reset_n,
  mlp_sequencer_if.master bus
);

  localparam int unsigned MAX_NR  = (N > ROWS) ? N : ROWS;
  localparam int unsigned CNT_MAX = (MAX_NR > LATENCY) ? MAX_NR : LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mlp_state_t        state, state_d;
  logic              accept;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic [ADDR_W-1:0] act_q, out_q;
  logic              acc_mode_q;

  mlp_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next state and phase-counter control
  always_comb begin
    state_d  = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    accept   = bus.mlp_start && can_accept(state);
    unique case (state)
      S_IDLE:   if (accept) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d  = S_LOAD_W;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(N - 1);
      end
      S_LOAD_W: if (!bus.wfifo_empty) begin
        if (cnt_zero) state_d = S_SWAP_W;
        else          cnt_dec = 1'b1;
      end
      S_SWAP_W: begin
        state_d  = S_STREAM;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(ROWS - 1);
      end
      S_STREAM: begin
        if (cnt_zero) begin
          state_d  = S_DRAIN;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(LATENCY - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_zero) state_d = S_COMMIT;
        else          cnt_dec = 1'b1;
      end
      S_COMMIT: begin
        state_d  = S_WRITEBACK;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(ROWS - 1);
      end
      S_WRITEBACK: if (bus.wb_valid && bus.wb_ready) begin
        if (cnt_zero) state_d = S_DONE;
        else          cnt_dec = 1'b1;
      end
      S_DONE:   state_d = accept ? S_CLEAR : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.mlp_state = STATE_W'(state);

  // Pop is gated by the live empty flag so it can never coincide with empty
  assign bus.wfifo_rd_en = (state == S_LOAD_W) && !bus.wfifo_empty;
  assign bus.wt_load_en  = (state == S_LOAD_W) && !bus.wfifo_empty;

  // Request fields captured on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q      <= '0;
      out_q      <= '0;
      acc_mode_q <= 1'b0;
    end else if (accept) begin
      act_q      <= bus.act_base;
      out_q      <= bus.out_base;
      acc_mode_q <= bus.mlp_accumulate_mode;
    end
  end

  // Registered strobes and addresses, decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.acc_clear     <= 1'b0;
      bus.wt_swap       <= 1'b0;
      bus.ub_rd_en      <= 1'b0;
      bus.ub_rd_addr    <= '0;
      bus.acc_commit    <= 1'b0;
      bus.acc_add       <= 1'b0;
      bus.wb_valid      <= 1'b0;
      bus.wb_addr       <= '0;
      bus.start_ignored <= 1'b0;
    end else begin
      bus.acc_clear     <= accept && bus.mlp_clear_acc && !bus.mlp_accumulate_mode;
      bus.wt_swap       <= (state_d == S_SWAP_W);
      bus.ub_rd_en      <= (state_d == S_STREAM);
      bus.acc_commit    <= (state_d == S_COMMIT);
      bus.acc_add       <= (state_d == S_COMMIT) && acc_mode_q;
      bus.wb_valid      <= (state_d == S_WRITEBACK);
      bus.start_ignored <= bus.mlp_start && !can_accept(state);
      if (state_d == S_STREAM)
        bus.ub_rd_addr <= (state == S_STREAM) ? bus.ub_rd_addr + ADDR_W'(1) : act_q;
      if (state_d == S_WRITEBACK) begin
        if (state != S_WRITEBACK) bus.wb_addr <= out_q;
        else if (bus.wb_ready)    bus.wb_addr <= bus.wb_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench for mlp_sequencer: per-cycle stimulus tables, a
// phase-schedule reference model, and one task per scenario.
module tb_mlp_sequencer;

  localparam int N    = 4;
  localparam int ROWS = 4;
  localparam int LAT  = 8;
  localparam int MAXC = 100;

  // Strobe vector: {rd_en, load_en, clear, swap, ub_en, commit, add, wb_valid, ignored}
  localparam logic [8:0] F_POP    = 9'h180;
  localparam logic [8:0] F_CLR    = 9'h040;
  localparam logic [8:0] F_SWAP   = 9'h020;
  localparam logic [8:0] F_UB     = 9'h010;
  localparam logic [8:0] F_COMMIT = 9'h008;
  localparam logic [8:0] F_ADD    = 9'h004;
  localparam logic [8:0] F_WB     = 9'h002;
  localparam logic [8:0] F_IGN    = 9'h001;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mlp_sequencer_if #(.ADDR_W(8)) bus ();

  mlp_sequencer #(.N(N), .ROWS(ROWS), .LATENCY(LAT), .ADDR_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errs   = 0;
  int checks = 0;

  logic       start_at [MAXC];
  logic       empty_at [MAXC];
  logic       ready_at [MAXC];
  logic       clr_at   [MAXC];
  logic       accm_at  [MAXC];
  logic [7:0] act_at   [MAXC];
  logic [7:0] out_at   [MAXC];

  logic [3:0] exp_state [MAXC+1];
  logic [8:0] exp_flags [MAXC+1];
  logic [7:0] exp_ub    [MAXC];
  logic [7:0] exp_wb    [MAXC];
  logic [3:0] obs_state [MAXC];
  logic [8:0] obs_flags [MAXC];
  logic [7:0] obs_ub    [MAXC];
  logic [7:0] obs_wb    [MAXC];

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      start_at[c] = 1'b0; empty_at[c] = 1'b0; ready_at[c] = 1'b1;
      clr_at[c] = 1'b0; accm_at[c] = 1'b0; act_at[c] = 8'h00; out_at[c] = 8'h00;
    end
  endtask

  function automatic void mark(input int c, input logic [3:0] st, input logic [8:0] fl);
    if (c < MAXC) begin
      exp_state[c] = st;
      exp_flags[c] = exp_flags[c] | fl;
    end
  endfunction

  // One pass beginning in cycle p (accept in p-1); returns the DONE cycle
  function automatic int run_pass(input int p);
    int c = p;
    int k;
    logic [7:0] act = act_at[p-1];
    logic [7:0] ob  = out_at[p-1];
    logic       am  = accm_at[p-1];
    logic       cl  = clr_at[p-1] & ~accm_at[p-1];
    mark(c, 4'd1, cl ? F_CLR : 9'h0); c++;
    k = 0;
    while (k < N && c < MAXC) begin
      mark(c, 4'd2, empty_at[c] ? 9'h0 : F_POP);
      if (!empty_at[c]) k++;
      c++;
    end
    mark(c, 4'd3, F_SWAP); c++;
    for (int i = 0; i < ROWS; i++) begin
      mark(c, 4'd4, F_UB);
      if (c < MAXC) exp_ub[c] = act + 8'(i);
      c++;
    end
    for (int i = 0; i < LAT; i++) begin mark(c, 4'd5, 9'h0); c++; end
    mark(c, 4'd6, am ? (F_COMMIT | F_ADD) : F_COMMIT); c++;
    k = 0;
    while (k < ROWS && c < MAXC) begin
      mark(c, 4'd7, F_WB);
      exp_wb[c] = ob + 8'(k);
      if (ready_at[c]) k++;
      c++;
    end
    mark(c, 4'd8, 9'h0);
    for (int i = p; i < c && i < MAXC; i++)
      if (start_at[i]) exp_flags[i+1] = exp_flags[i+1] | F_IGN;
    return c;
  endfunction

  function automatic void build_model(input int n);
    int t = 0;
    for (int c = 0; c <= MAXC; c++) begin exp_state[c] = 4'd0; exp_flags[c] = 9'h0; end
    for (int c = 0; c < MAXC; c++) begin exp_ub[c] = 8'h0; exp_wb[c] = 8'h0; end
    while (t < n) begin
      if (start_at[t]) t = run_pass(t + 1);
      else t++;
    end
  endfunction

  // Drive cycle c just after its edge, sample at the following negedge
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      bus.mlp_start = start_at[c]; bus.mlp_clear_acc = clr_at[c];
      bus.mlp_accumulate_mode = accm_at[c]; bus.act_base = act_at[c];
      bus.out_base = out_at[c]; bus.wfifo_empty = empty_at[c]; bus.wb_ready = ready_at[c];
      @(negedge clk);
      obs_state[c] = bus.mlp_state;
      obs_flags[c] = {bus.wfifo_rd_en, bus.wt_load_en, bus.acc_clear, bus.wt_swap, bus.ub_rd_en,
                      bus.acc_commit, bus.acc_add, bus.wb_valid, bus.start_ignored};
      obs_ub[c] = bus.ub_rd_addr;
      obs_wb[c] = bus.wb_addr;
      @(posedge clk); #1;
    end
    bus.mlp_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.mlp_start = 1'b0; bus.mlp_clear_acc = 1'b0; bus.mlp_accumulate_mode = 1'b0;
    bus.act_base = 8'h0; bus.out_base = 8'h0; bus.wfifo_empty = 1'b0; bus.wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mlp_state !== 4'd0) begin
      errs++; $display("FAIL reset state got=%0d exp=0", bus.mlp_state);
    end
    checks++;
    if ({bus.wfifo_rd_en, bus.wt_load_en, bus.wt_swap, bus.ub_rd_en, bus.ub_rd_addr, bus.acc_clear,
         bus.acc_commit, bus.acc_add, bus.wb_valid, bus.wb_addr, bus.start_ignored} !== 29'h0) begin
      errs++; $display("FAIL reset outputs not all zero");
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clear_pass();
    clear_stim();
    start_at[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin clr_at[c] = 1'b1; act_at[c] = 8'h10; out_at[c] = 8'h40; end
    build_model(30);
    run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL clear_pass state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL clear_pass strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
      if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL clear_pass ub_rd_addr c=%0d got=%h exp=%h", c, obs_ub[c], exp_ub[c]); end end
      if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL clear_pass wb_addr c=%0d got=%h exp=%h", c, obs_wb[c], exp_wb[c]); end end
    end
    checks++; if (obs_state[24] !== 4'd8) begin errs++; $display("FAIL clear_pass done_cycle got=%0d exp=8", obs_state[24]); end
    checks++; if (obs_flags[19] !== F_COMMIT) begin errs++; $display("FAIL clear_pass commit_cycle got=%b exp=%b", obs_flags[19], F_COMMIT); end
    checks++; if (obs_ub[10] !== 8'h13) begin errs++; $display("FAIL clear_pass last_act_addr got=%h exp=13", obs_ub[10]); end
  endtask

  task automatic test_accumulate();
    int nclr = 0;
    clear_stim();
    start_at[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      clr_at[c] = 1'b1; accm_at[c] = 1'b1;
      act_at[c] = 8'($urandom_range(0, 255)); out_at[c] = 8'($urandom_range(0, 255));
    end
    build_model(30);
    run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      if (obs_flags[c][6]) nclr++;
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL accumulate state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL accumulate strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
      if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL accumulate ub_rd_addr c=%0d got=%h exp=%h", c, obs_ub[c], exp_ub[c]); end end
      if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL accumulate wb_addr c=%0d got=%h exp=%h", c, obs_wb[c], exp_wb[c]); end end
    end
    checks++; if (nclr !== 0) begin errs++; $display("FAIL accumulate acc_clear_count got=%0d exp=0", nclr); end
    checks++; if (obs_flags[19] !== (F_COMMIT | F_ADD)) begin errs++; $display("FAIL accumulate add_at_commit got=%b exp=%b", obs_flags[19], F_COMMIT | F_ADD); end
  endtask

  task automatic test_fifo_stall();
    int npop = 0;
    clear_stim();
    start_at[0] = 1'b1;
    for (int c = 3; c <= 5; c++) empty_at[c] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin act_at[c] = 8'h21; out_at[c] = 8'h77; end
    build_model(32);
    run_cycles(32);
    for (int c = 0; c < 32; c++) begin
      if (obs_flags[c][8]) npop++;
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL fifo_stall state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL fifo_stall strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
      if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL fifo_stall ub_rd_addr c=%0d got=%h exp=%h", c, obs_ub[c], exp_ub[c]); end end
      if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL fifo_stall wb_addr c=%0d got=%h exp=%h", c, obs_wb[c], exp_wb[c]); end end
    end
    checks++; if (npop !== 4) begin errs++; $display("FAIL fifo_stall pop_count got=%0d exp=4", npop); end
    checks++; if (obs_state[27] !== 4'd8) begin errs++; $display("FAIL fifo_stall done_cycle got=%0d exp=8", obs_state[27]); end
  endtask

  task automatic test_wb_backpressure();
    clear_stim();
    start_at[0] = 1'b1;
    ready_at[21] = 1'b0; ready_at[22] = 1'b0;
    for (int c = 0; c < MAXC; c++) begin act_at[c] = 8'hFD; out_at[c] = 8'hFE; end
    build_model(30);
    run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL wb_backpressure state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL wb_backpressure strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
      if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL wb_backpressure ub_rd_addr c=%0d got=%h exp=%h", c, obs_ub[c], exp_ub[c]); end end
      if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL wb_backpressure wb_addr c=%0d got=%h exp=%h", c, obs_wb[c], exp_wb[c]); end end
    end
    checks++; if (obs_wb[23] !== 8'hFF) begin errs++; $display("FAIL wb_backpressure held_addr got=%h exp=ff", obs_wb[23]); end
    checks++; if (obs_wb[24] !== 8'h00) begin errs++; $display("FAIL wb_backpressure wrap_addr got=%h exp=00", obs_wb[24]); end
    checks++; if (obs_wb[25] !== 8'h01) begin errs++; $display("FAIL wb_backpressure last_addr got=%h exp=01", obs_wb[25]); end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    start_at[0] = 1'b1; start_at[13] = 1'b1; start_at[24] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      clr_at[c] = (c >= 24);
      act_at[c] = (c >= 24) ? 8'h80 : 8'h20;
      out_at[c] = (c >= 24) ? 8'h90 : 8'h30;
    end
    build_model(52);
    run_cycles(52);
    for (int c = 0; c < 52; c++) begin
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL back_to_back state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL back_to_back strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
      if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL back_to_back ub_rd_addr c=%0d got=%h exp=%h", c, obs_ub[c], exp_ub[c]); end end
      if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL back_to_back wb_addr c=%0d got=%h exp=%h", c, obs_wb[c], exp_wb[c]); end end
    end
    checks++; if (obs_flags[14] !== F_IGN) begin errs++; $display("FAIL back_to_back ignored_pulse got=%b exp=%b", obs_flags[14], F_IGN); end
    checks++; if (obs_state[25] !== 4'd1) begin errs++; $display("FAIL back_to_back done_to_clear got=%0d exp=1", obs_state[25]); end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    start_at[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin act_at[c] = 8'h55; out_at[c] = 8'h66; end
    build_model(10);
    run_cycles(10);
    for (int c = 0; c < 10; c++) begin
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL reset_mid pre_state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL reset_mid pre_strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mlp_state !== 4'd0) begin errs++; $display("FAIL reset_mid state got=%0d exp=0", bus.mlp_state); end
    checks++;
    if ({bus.wfifo_rd_en, bus.wt_load_en, bus.wt_swap, bus.ub_rd_en, bus.ub_rd_addr, bus.acc_clear,
         bus.acc_commit, bus.acc_add, bus.wb_valid, bus.wb_addr, bus.start_ignored} !== 29'h0) begin
      errs++; $display("FAIL reset_mid outputs not all zero");
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_stim();
    start_at[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin clr_at[c] = 1'b1; act_at[c] = 8'hA0; out_at[c] = 8'hB0; end
    build_model(30);
    run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL reset_mid state c=%0d got=%0d exp=%0d", c, obs_state[c], exp_state[c]); end
      checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL reset_mid strobes c=%0d got=%b exp=%b", c, obs_flags[c], exp_flags[c]); end
      if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL reset_mid ub_rd_addr c=%0d got=%h exp=%h", c, obs_ub[c], exp_ub[c]); end end
      if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL reset_mid wb_addr c=%0d got=%h exp=%h", c, obs_wb[c], exp_wb[c]); end end
    end
  endtask

  task automatic test_random();
    int s0;
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      s0 = int'($urandom_range(0, 3));
      start_at[s0] = 1'b1;
      for (int c = 0; c < MAXC; c++) begin
        clr_at[c]  = 1'($urandom_range(0, 1));
        accm_at[c] = 1'($urandom_range(0, 1));
        act_at[c]  = 8'($urandom_range(0, 255));
        out_at[c]  = 8'($urandom_range(0, 255));
        if (c < 40) empty_at[c] = ($urandom_range(0, 3) == 0);
        if (c < 60) ready_at[c] = ($urandom_range(0, 3) != 0);
        if (c > s0 && c < s0 + 20) start_at[c] = ($urandom_range(0, 5) == 0);
      end
      build_model(90);
      run_cycles(90);
      for (int c = 0; c < 90; c++) begin
        checks++; if (obs_state[c] !== exp_state[c]) begin errs++; $display("FAIL random%0d state c=%0d got=%0d exp=%0d", it, c, obs_state[c], exp_state[c]); end
        checks++; if (obs_flags[c] !== exp_flags[c]) begin errs++; $display("FAIL random%0d strobes c=%0d got=%b exp=%b", it, c, obs_flags[c], exp_flags[c]); end
        if (exp_flags[c][4]) begin checks++; if (obs_ub[c] !== exp_ub[c]) begin errs++; $display("FAIL random%0d ub_rd_addr c=%0d got=%h exp=%h", it, c, obs_ub[c], exp_ub[c]); end end
        if (exp_flags[c][1]) begin checks++; if (obs_wb[c] !== exp_wb[c]) begin errs++; $display("FAIL random%0d wb_addr c=%0d got=%h exp=%h", it, c, obs_wb[c], exp_wb[c]); end end
      end
    end
  endtask

  initial begin
    clear_stim();
    test_reset();
    test_clear_pass();
    test_accumulate();
    test_fifo_stall();
    test_wb_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
